stack_share_arb: RTL and testbench
==================================

Name: stack_share_arb

Overview:
- Shares one single-port SRAM between two stack clients: the data stack (DS, grows up from address 0) and the return stack (RS, grows down from DEPTH-1).
- Tracks per-stack depth, detects overflow/underflow against the shared free space, round-robin arbitrates simultaneous requests, and sequences each RAM access over a 2-cycle grant/ack handshake.
- Sits between the core's stack-op decode and the sram instance.

Parameters:
- WIDTH, 16, data width of stack entries.
- DEPTH, 512, total SRAM entries shared by both stacks (power of two, >= 4).
- AW (localparam), $clog2(DEPTH), RAM address width; depth counters are AW+1 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ds_req  in  1  DS request; held high until ds_ack.
- ds_op  in  1  0 = push, 1 = pop; stable while ds_req.
- ds_wd  in  WIDTH  push data; stable while ds_req.
- ds_ack  out  1  one-cycle completion pulse.
- ds_err  out  1  qualifies ds_ack; op rejected.
- ds_rd  out  WIDTH  popped value; valid only when ds_ack & pop & !ds_err.
- ds_depth  out  AW+1  current DS entry count.
- rs_req, rs_op, rs_wd, rs_ack, rs_err, rs_rd, rs_depth: same as DS for the return stack.
- ram_addr  out  AW  SRAM address; the SRAM registers it internally, so read data returns the next cycle.
- ram_wdata  out  WIDTH  SRAM write data.
- ram_we  out  1  SRAM write enable.
- ram_rdata  in  WIDTH  SRAM read data.

Behaviour:
- FSM states: IDLE, DS_ACC, RS_ACC.
- IDLE:
  - If any req is high, grant one requester. The grant drives ram_addr, ram_wdata and ram_we combinationally in the same cycle.
  - Go to X_ACC for the granted stack.
- X_ACC:
  - Assert X_ack (registered, exactly one cycle); X_rd = ram_rdata.
  - Return to IDLE. No grant is issued in this state.
  - Throughput is one op per 2 cycles.
- Client handshake: a client drops req, or presents a new op, in the cycle after ack. req is sampled only in IDLE.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesting: the one not granted last wins.
  - last_grant resets to RS, so DS wins the first tie.
- Addressing, with free = DEPTH - ds_depth - rs_depth:
  - DS push: write at ds_depth; ds_depth+1.
  - DS pop: read at ds_depth-1; ds_depth-1.
  - RS push: write at DEPTH-1-rs_depth; rs_depth+1.
  - RS pop: read at DEPTH-rs_depth; rs_depth-1.
  - Depth counters update at the grant edge.
- Overflow: push with free == 0 gives no RAM access (ram_we=0), depth unchanged, ack with err=1.
- Underflow: pop with X_depth == 0 gives no RAM access, ack with err=1, X_rd undefined.
- Simultaneous DS push and RS push when free == 1: the arbitration winner succeeds. The loser is granted next and errors.
- Outside a grant cycle: ram_we=0, ram_addr=0, ram_wdata=0.
- Reset, including mid-operation:
  - state=IDLE, all ack/err=0, depths=0, last_grant=RS, ram_we=0.
  - A pending access is abandoned with no ack. SRAM contents are not cleared.
- Depth never wraps. Sum of depths is always <= DEPTH.

Optional Feature:
- STACK_HWM_EN defined:
  - Adds outputs ds_hwm and rs_hwm (AW+1 each): the maximum depth reached since reset.
  - Each updates on the grant edge when the new depth exceeds it; errored ops never update it.
- STACK_HWM_EN undefined: the ports and registers are absent.

Decomposition:
- Package stack_arb_pkg:
  - op encoding (OP_PUSH=0, OP_POP=1).
  - FSM state enum (IDLE, DS_ACC, RS_ACC).
  - grant id enum (GNT_DS, GNT_RS).
- Sub-module rr_arb2: 2-way round-robin arbiter with last_grant register, an update-enable input and one-hot grant output.

Test Plan:
- DS push 0x1234 then DS pop: ram_we=1 at addr 0; next op reads addr 0; ds_ack on cycles 2 and 4; ds_rd=0x1234, ds_err=0; ds_depth goes 1 then 0.
- RS push 0xBEEF (DEPTH=512): ram_addr=511, rs_depth=1. RS pop returns 0xBEEF from addr 511.
- ds_req and rs_req both held high from reset: grants go DS, RS, DS, RS; acks are 2 cycles apart.
- Fill: 510 DS pushes plus 2 RS pushes, then DS push: ds_ack with ds_err=1, ram_we stays 0, ds_depth=510. Pop on the empty side likewise gives err=1.
- rst asserted in DS_ACC: next cycle ds_ack=0, depths=0, state IDLE. A following DS pop returns err=1.
- STACK_HWM_EN: push 3, pop 2, push 1 gives ds_hwm=3, ds_depth=2. An overflow attempt leaves hwm unchanged.

Source files
------------

// File: rtl/stack_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_arb_pkg
// Description : Shared encodings for the stack-sharing SRAM arbiter:
//               stack op codes, arbiter FSM states and grant identifiers.
// Revision    : 1.0  initial release
// ============================================================================
package stack_arb_pkg;

  // Stack operation encoding carried on the X_op inputs
  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DS_ACC = 2'd1,
    RS_ACC = 2'd2
  } state_t;

  // Identity of the most recently granted client
  typedef enum logic {
    GNT_DS = 1'b0,
    GNT_RS = 1'b1
  } gnt_id_t;

endpackage : stack_arb_pkg
`default_nettype wire

// File: rtl/stack_share_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. Bit 0 is the data stack, bit 1
//               the return stack. On a tie the client not granted last wins.
//               The last-grant register advances only when update_en is high
//               and a grant is issued.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               req[1:0]       - request vector {rs, ds}
//               update_en      - allow last-grant to advance this cycle
//               gnt[1:0]       - one-hot grant {rs, ds}
// Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
  import stack_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] gnt
);

  gnt_id_t r_last;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (r_last == GNT_RS) ? 2'b01 : 2'b10;
    end
  end

  // Reset value RS makes the data stack win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= GNT_RS;
    end else if (update_en && (gnt != 2'b00)) begin
      r_last <= gnt[1] ? GNT_RS : GNT_DS;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/stack_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : stack_share_arb
// Description : Shares one single-port SRAM between the data stack (grows up
//               from address 0) and the return stack (grows down from
//               DEPTH-1). Tracks depths, rejects overflow/underflow against
//               the shared free space, round-robin arbitrates and runs each
//               access as a grant cycle followed by an ack cycle.
// Ports       : clk, rst                     - clock, sync active-high reset
//               ds_req/op/wd, ds_ack/err/rd  - data stack client
//               ds_depth                     - data stack entry count
//               rs_*                         - return stack client (same)
//               ds_hwm, rs_hwm               - max depth since reset
//                                              (only with STACK_HWM_EN)
//               ram_addr/wdata/we, ram_rdata - SRAM (1-cycle read latency)
// Options     : `define STACK_HWM_EN adds the high-water-mark outputs.
// Revision    : 1.0  initial release
// ============================================================================
module stack_share_arb
  import stack_arb_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ds_req,
  input  logic             ds_op,
  input  logic [WIDTH-1:0] ds_wd,
  output logic             ds_ack,
  output logic             ds_err,
  output logic [WIDTH-1:0] ds_rd,
  output logic [AW:0]      ds_depth,
  input  logic             rs_req,
  input  logic             rs_op,
  input  logic [WIDTH-1:0] rs_wd,
  output logic             rs_ack,
  output logic             rs_err,
  output logic [WIDTH-1:0] rs_rd,
  output logic [AW:0]      rs_depth,
`ifdef STACK_HWM_EN
  output logic [AW:0]      ds_hwm,
  output logic [AW:0]      rs_hwm,
`endif
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_we,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam logic [AW:0]   c_DEPTH_N = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_ONE_N   = (AW+1)'(1);
  localparam logic [AW-1:0] c_ONE_A   = AW'(1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ds_ack, r_ds_err, r_rs_ack, r_rs_err;
  logic [AW:0] r_ds_depth, r_rs_depth;

  logic        w_arb_en;
  logic [1:0]  w_req, w_gnt;
  logic        w_gnt_ds, w_gnt_rs;
  logic [AW:0] w_free;
  logic        w_ds_ok, w_rs_ok;
  logic [AW:0] w_ds_inc, w_ds_dec, w_rs_inc, w_rs_dec;
  logic [AW-1:0] w_ds_push_addr, w_ds_pop_addr;
  logic [AW-1:0] w_rs_push_addr, w_rs_pop_addr;

  // Requests are only considered in IDLE; reset also suppresses any grant so
  // the RAM sees no write in a reset cycle.
  assign w_arb_en = (r_state == IDLE) && !rst;
  assign w_req    = {rs_req, ds_req} & {2{w_arb_en}};

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (w_req),
    .update_en (w_arb_en),
    .gnt       (w_gnt)
  );

  assign w_gnt_ds = w_gnt[0];
  assign w_gnt_rs = w_gnt[1];

  assign w_free   = c_DEPTH_N - r_ds_depth - r_rs_depth;
  assign w_ds_ok  = (ds_op == OP_PUSH) ? (w_free != '0) : (r_ds_depth != '0);
  assign w_rs_ok  = (rs_op == OP_PUSH) ? (w_free != '0) : (r_rs_depth != '0);

  assign w_ds_inc = r_ds_depth + c_ONE_N;
  assign w_ds_dec = r_ds_depth - c_ONE_N;
  assign w_rs_inc = r_rs_depth + c_ONE_N;
  assign w_rs_dec = r_rs_depth - c_ONE_N;

  // A successful DS push implies ds_depth < DEPTH, so the low AW bits are the
  // address. RS push lands at DEPTH-1-rs_depth, i.e. the bitwise complement
  // for a power-of-two DEPTH; RS pop is one above that (wraps to 0 when the
  // return stack holds every entry).
  assign w_ds_push_addr = r_ds_depth[AW-1:0];
  assign w_ds_pop_addr  = w_ds_dec[AW-1:0];
  assign w_rs_push_addr = ~r_rs_depth[AW-1:0];
  assign w_rs_pop_addr  = w_rs_push_addr + c_ONE_A;

  always_comb begin
    w_state_nxt = r_state;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_ds) begin
          w_state_nxt = DS_ACC;
          if (w_ds_ok) begin
            if (ds_op == OP_PUSH) begin
              ram_we    = 1'b1;
              ram_addr  = w_ds_push_addr;
              ram_wdata = ds_wd;
            end else begin
              ram_addr  = w_ds_pop_addr;
            end
          end
        end else if (w_gnt_rs) begin
          w_state_nxt = RS_ACC;
          if (w_rs_ok) begin
            if (rs_op == OP_PUSH) begin
              ram_we    = 1'b1;
              ram_addr  = w_rs_push_addr;
              ram_wdata = rs_wd;
            end else begin
              ram_addr  = w_rs_pop_addr;
            end
          end
        end
      end
      DS_ACC:  w_state_nxt = IDLE;
      RS_ACC:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ack/err are captured at the grant edge so they are high for exactly the
  // access cycle, when the SRAM read data is also present.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ds_ack   <= 1'b0;
      r_ds_err   <= 1'b0;
      r_rs_ack   <= 1'b0;
      r_rs_err   <= 1'b0;
      r_ds_depth <= '0;
      r_rs_depth <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ds_ack <= w_gnt_ds;
      r_ds_err <= w_gnt_ds & ~w_ds_ok;
      r_rs_ack <= w_gnt_rs;
      r_rs_err <= w_gnt_rs & ~w_rs_ok;
      if (w_gnt_ds && w_ds_ok) begin
        r_ds_depth <= (ds_op == OP_PUSH) ? w_ds_inc : w_ds_dec;
      end
      if (w_gnt_rs && w_rs_ok) begin
        r_rs_depth <= (rs_op == OP_PUSH) ? w_rs_inc : w_rs_dec;
      end
    end
  end

`ifdef STACK_HWM_EN
  logic [AW:0] r_ds_hwm, r_rs_hwm;

  // Only a successful push can raise depth, so errored ops never touch these.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ds_hwm <= '0;
      r_rs_hwm <= '0;
    end else begin
      if (w_gnt_ds && w_ds_ok && (ds_op == OP_PUSH) && (w_ds_inc > r_ds_hwm)) begin
        r_ds_hwm <= w_ds_inc;
      end
      if (w_gnt_rs && w_rs_ok && (rs_op == OP_PUSH) && (w_rs_inc > r_rs_hwm)) begin
        r_rs_hwm <= w_rs_inc;
      end
    end
  end

  assign ds_hwm = r_ds_hwm;
  assign rs_hwm = r_rs_hwm;
`endif

  assign ds_ack   = r_ds_ack;
  assign ds_err   = r_ds_err;
  assign rs_ack   = r_rs_ack;
  assign rs_err   = r_rs_err;
  assign ds_rd    = ram_rdata;
  assign rs_rd    = ram_rdata;
  assign ds_depth = r_ds_depth;
  assign rs_depth = r_rs_depth;

endmodule : stack_share_arb
`default_nettype wire

// File: tb/tb_stack_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_share_arb
// Description : Directed self-checking bench for stack_share_arb with a
//               behavioural SRAM (address registered, read data next cycle).
// Revision    : 1.0  initial release
// ============================================================================
module tb_stack_share_arb;

  localparam int WIDTH = 16;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             ds_req, ds_op, rs_req, rs_op;
  logic [WIDTH-1:0] ds_wd, rs_wd, ds_rd, rs_rd;
  logic             ds_ack, ds_err, rs_ack, rs_err;
  logic [AW:0]      ds_depth, rs_depth;
`ifdef STACK_HWM_EN
  logic [AW:0]      ds_hwm, rs_hwm;
`endif
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata, ram_rdata;
  logic             ram_we;

  logic [WIDTH-1:0] mem [DEPTH];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  stack_share_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ds_req    (ds_req),
    .ds_op     (ds_op),
    .ds_wd     (ds_wd),
    .ds_ack    (ds_ack),
    .ds_err    (ds_err),
    .ds_rd     (ds_rd),
    .ds_depth  (ds_depth),
    .rs_req    (rs_req),
    .rs_op     (rs_op),
    .rs_wd     (rs_wd),
    .rs_ack    (rs_ack),
    .rs_err    (rs_err),
    .rs_rd     (rs_rd),
    .rs_depth  (rs_depth),
`ifdef STACK_HWM_EN
    .ds_hwm    (ds_hwm),
    .rs_hwm    (rs_hwm),
`endif
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Entered and left at posedge+1. Captures the RAM port in the grant cycle
  // and the ack/err/rd values in the ack cycle.
  task automatic run_op(input bit is_rs, input logic op, input logic [WIDTH-1:0] wd,
                        output logic err, output logic [WIDTH-1:0] rd,
                        output logic we_g, output logic [AW-1:0] addr_g,
                        output int lat);
    bit got;
    got = 0; err = 1'bx; rd = 'x;
    if (is_rs) begin rs_req = 1'b1; rs_op = op; rs_wd = wd; end
    else       begin ds_req = 1'b1; ds_op = op; ds_wd = wd; end
    @(negedge clk);
    lat = 1; we_g = ram_we; addr_g = ram_addr;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (is_rs ? rs_ack : ds_ack) begin
        got = 1;
        err = is_rs ? rs_err : ds_err;
        rd  = is_rs ? rs_rd  : ds_rd;
      end
    end
    if (!got) chk("ack_timeout", 32'(lat), 32'd2);
    @(posedge clk); #1;
    ds_req = 1'b0; rs_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic             e, we;
  logic [WIDTH-1:0] rd;
  logic [AW-1:0]    a;
  int               lat, nerr;

  initial begin
    rst = 1'b1; ds_req = 0; rs_req = 0; ds_op = 0; rs_op = 0; ds_wd = 0; rs_wd = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ds_ack", 32'(ds_ack), 0);
    chk("rst_rs_ack", 32'(rs_ack), 0);
    chk("rst_ds_depth", 32'(ds_depth), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // DS push then pop
    run_op(0, 1'b0, 16'h1234, e, rd, we, a, lat);
    chk("ds_push_we", 32'(we), 1);
    chk("ds_push_addr", 32'(a), 0);
    chk("ds_push_lat", 32'(lat), 2);
    chk("ds_push_err", 32'(e), 0);
    chk("ds_push_depth", 32'(ds_depth), 1);
    run_op(0, 1'b1, 16'h0, e, rd, we, a, lat);
    chk("ds_pop_we", 32'(we), 0);
    chk("ds_pop_addr", 32'(a), 0);
    chk("ds_pop_lat", 32'(lat), 2);
    chk("ds_pop_err", 32'(e), 0);
    chk("ds_pop_rd", 32'(rd), 32'h1234);
    chk("ds_pop_depth", 32'(ds_depth), 0);

    // RS push then pop, then underflow on the empty return stack
    run_op(1, 1'b0, 16'hBEEF, e, rd, we, a, lat);
    chk("rs_push_addr", 32'(a), 511);
    chk("rs_push_we", 32'(we), 1);
    chk("rs_push_depth", 32'(rs_depth), 1);
    run_op(1, 1'b1, 16'h0, e, rd, we, a, lat);
    chk("rs_pop_addr", 32'(a), 511);
    chk("rs_pop_rd", 32'(rd), 32'hBEEF);
    chk("rs_pop_err", 32'(e), 0);
    chk("rs_pop_depth", 32'(rs_depth), 0);
    run_op(1, 1'b1, 16'h0, e, rd, we, a, lat);
    chk("rs_under_err", 32'(e), 1);
    chk("rs_under_we", 32'(we), 0);
    chk("rs_under_depth", 32'(rs_depth), 0);

    // Both requesting from reset: DS, RS, DS, RS
    rst = 1'b1;
    ds_req = 1; ds_op = 0; ds_wd = 16'hA1A1;
    rs_req = 1; rs_op = 0; rs_wd = 16'hB2B2;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("rr_acks_c%0d", k), 32'({rs_ack, ds_ack}),
          (k % 2 == 1) ? 32'd0 : ((k % 4 == 2) ? 32'd1 : 32'd2));
      if (k == 1) chk("rr_addr_c1", 32'(ram_addr), 0);
      if (k == 3) chk("rr_addr_c3", 32'(ram_addr), 511);
      if (k == 5) chk("rr_addr_c5", 32'(ram_addr), 1);
      if (k == 7) chk("rr_addr_c7", 32'(ram_addr), 510);
    end
    @(posedge clk); #1;
    ds_req = 0; rs_req = 0;
    chk("rr_ds_depth", 32'(ds_depth), 2);
    chk("rr_rs_depth", 32'(rs_depth), 2);

    // Reset while in DS_ACC
    ds_req = 1; ds_op = 0; ds_wd = 16'h5555;
    @(posedge clk); #1;
    rst = 1'b1; ds_req = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ds_ack", 32'(ds_ack), 0);
    chk("midrst_ds_depth", 32'(ds_depth), 0);
    chk("midrst_rs_depth", 32'(rs_depth), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(0, 1'b1, 16'h0, e, rd, we, a, lat);
    chk("midrst_pop_err", 32'(e), 1);
    chk("midrst_pop_lat", 32'(lat), 2);

`ifdef STACK_HWM_EN
    do_reset();
    for (int i = 0; i < 3; i++) run_op(0, 1'b0, 16'(i), e, rd, we, a, lat);
    for (int i = 0; i < 2; i++) run_op(0, 1'b1, 16'h0, e, rd, we, a, lat);
    run_op(0, 1'b0, 16'h7, e, rd, we, a, lat);
    chk("hwm_ds", 32'(ds_hwm), 3);
    chk("hwm_ds_depth", 32'(ds_depth), 2);
    chk("hwm_rs", 32'(rs_hwm), 0);
`endif

    // Fill: 510 DS + 2 RS pushes, then overflow on both sides
    do_reset();
    nerr = 0;
    for (int i = 0; i < 510; i++) begin
      run_op(0, 1'b0, 16'(i), e, rd, we, a, lat);
      if (e !== 1'b0) nerr++;
    end
    for (int i = 0; i < 2; i++) begin
      run_op(1, 1'b0, 16'hC000 + 16'(i), e, rd, we, a, lat);
      if (e !== 1'b0) nerr++;
    end
    chk("fill_errs", 32'(nerr), 0);
    chk("fill_ds_depth", 32'(ds_depth), 510);
    chk("fill_rs_depth", 32'(rs_depth), 2);
    run_op(0, 1'b0, 16'hDEAD, e, rd, we, a, lat);
    chk("ovf_ds_err", 32'(e), 1);
    chk("ovf_ds_we", 32'(we), 0);
    chk("ovf_ds_depth", 32'(ds_depth), 510);
`ifdef STACK_HWM_EN
    chk("ovf_ds_hwm", 32'(ds_hwm), 510);
`endif
    run_op(1, 1'b0, 16'hDEAD, e, rd, we, a, lat);
    chk("ovf_rs_err", 32'(e), 1);
    chk("ovf_rs_depth", 32'(rs_depth), 2);
    run_op(0, 1'b1, 16'h0, e, rd, we, a, lat);
    chk("fill_pop_addr", 32'(a), 509);
    chk("fill_pop_rd", 32'(rd), 509);
    chk("fill_pop_depth", 32'(ds_depth), 509);

    // free == 1, both push: last grant was DS so RS wins, DS then errors
    ds_req = 1; ds_op = 0; ds_wd = 16'h1111;
    rs_req = 1; rs_op = 0; rs_wd = 16'h2222;
    @(negedge clk);
    chk("tie_we_c1", 32'(ram_we), 1);
    chk("tie_addr_c1", 32'(ram_addr), 509);
    chk("tie_wdata_c1", 32'(ram_wdata), 32'h2222);
    @(negedge clk);
    chk("tie_acks_c2", 32'({rs_ack, rs_err, ds_ack}), 32'b100);
    @(posedge clk); #1;
    rs_req = 0;
    @(negedge clk);
    chk("tie_we_c3", 32'(ram_we), 0);
    @(negedge clk);
    chk("tie_acks_c4", 32'({ds_ack, ds_err, rs_ack}), 32'b110);
    @(posedge clk); #1;
    ds_req = 0;
    chk("tie_rs_depth", 32'(rs_depth), 3);
    chk("tie_ds_depth", 32'(ds_depth), 509);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_stack_share_arb
`default_nettype wire
